// File: rtl/umtrx_rx_vita_mux.sv
// Two-input VITA packet multiplexer: arbitrates whole packets (SOF..EOF) from two rx
// chains onto one output stream, with per-input forwarded-packet counters.
module umtrx_rx_vita_mux #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 clear,
  input  logic [35:0]          in0_tdata,
  input  logic                 in0_tvalid,
  output logic                 in0_tready,
  input  logic [35:0]          in1_tdata,
  input  logic                 in1_tvalid,
  output logic                 in1_tready,
  output logic [35:0]          out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1
);

  localparam int unsigned EOF_BIT = 33;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_q;       // 1 = input 1 was served last
  logic   pkt_done0_c;
  logic   pkt_done1_c;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: registered arbitration in IDLE, release of the grant on EOF transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (PRIO_MODE == 1) begin
          if (in0_tvalid)      state_d = GRANT0;
          else if (in1_tvalid) state_d = GRANT1;
        end else begin
          if (in0_tvalid && in1_tvalid) state_d = last_q ? GRANT0 : GRANT1;
          else if (in0_tvalid)          state_d = GRANT0;
          else if (in1_tvalid)          state_d = GRANT1;
        end
      end
      GRANT0: if (in0_tvalid && out_tready && in0_tdata[EOF_BIT]) state_d = IDLE;
      GRANT1: if (in1_tvalid && out_tready && in1_tdata[EOF_BIT]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Outputs: combinational pass-through of the granted input
  always_comb begin
    grant       = 2'b00;
    in0_tready  = 1'b0;
    in1_tready  = 1'b0;
    out_tvalid  = 1'b0;
    out_tdata   = '0;
    pkt_done0_c = 1'b0;
    pkt_done1_c = 1'b0;
    unique case (state_q)
      GRANT0: begin
        grant       = 2'b01;
        out_tdata   = in0_tdata;
        out_tvalid  = in0_tvalid;
        in0_tready  = out_tready;
        pkt_done0_c = in0_tvalid && out_tready && in0_tdata[EOF_BIT];
      end
      GRANT1: begin
        grant       = 2'b10;
        out_tdata   = in1_tdata;
        out_tvalid  = in1_tvalid;
        in1_tready  = out_tready;
        pkt_done1_c = in1_tvalid && out_tready && in1_tdata[EOF_BIT];
      end
      default: ;
    endcase
  end

  // Packet counters and last-served tracking; clear wins over a same-cycle EOF
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      last_q   <= 1'b1;
    end else if (clear) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      last_q   <= 1'b0;
    end else begin
      if (pkt_done0_c) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
        last_q   <= 1'b0;
      end
      if (pkt_done1_c) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
        last_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_umtrx_rx_vita_mux.sv
// Scoreboard bench for umtrx_rx_vita_mux: random packet sources feed per-input expected
// queues; a negedge monitor pops and compares against a packet-level arbitration model.
module tb_umtrx_rx_vita_mux;

  localparam int unsigned CW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [35:0]   d [2];
  logic          v [2];
  logic          out_tready = 1'b0;
  logic          in0_tready, in1_tready, out_tvalid;
  logic [35:0]   out_tdata;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  // Fixed-priority instance: both inputs permanently valid, output always ready
  logic [35:0] p_d0;
  logic [35:0] p_d1 = 36'h3_1234_5678;
  logic        p_tr0, p_tr1, p_ov;
  logic [35:0] p_od;
  logic [1:0]  p_gr;
  logic [15:0] p_c0, p_c1;

  umtrx_rx_vita_mux #(.PRIO_MODE(0), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear),
    .in0_tdata(d[0]), .in0_tvalid(v[0]), .in0_tready(in0_tready),
    .in1_tdata(d[1]), .in1_tvalid(v[1]), .in1_tready(in1_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  umtrx_rx_vita_mux #(.PRIO_MODE(1), .CNT_WIDTH(16)) dut_pr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear),
    .in0_tdata(p_d0), .in0_tvalid(1'b1), .in0_tready(p_tr0),
    .in1_tdata(p_d1), .in1_tvalid(1'b1), .in1_tready(p_tr1),
    .out_tdata(p_od), .out_tvalid(p_ov), .out_tready(1'b1),
    .grant(p_gr), .pkt_cnt0(p_c0), .pkt_cnt1(p_c1)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected words per input, pushed when a source creates a packet
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Stimulus knobs
  bit gen_en [2];
  int min_len = 1, max_len = 1, stall_pct = 0, rdy_pct = 100;

  // Model state
  int m_owner = -1;
  int m_last = 1;
  int m_cnt0 = 0, m_cnt1 = 0;
  int gwords = 0;
  bit xf0 = 1'b0, xf1 = 1'b0;

  always @(negedge sys_clk) begin : monitor
    int nxt, n;
    logic [35:0] w;
    if (!sys_rst_n) begin
      chk("rst_grant", 64'(grant), 0);
      chk("rst_ovalid", 64'(out_tvalid), 0);
      m_owner = -1; m_last = 1; m_cnt0 = 0; m_cnt1 = 0; gwords = 0;
      xf0 = 1'b0; xf1 = 1'b0;
    end else begin
      chk("grant", 64'(grant), (m_owner < 0) ? 0 : ((m_owner == 0) ? 1 : 2));
      chk("cnt0", 64'(pkt_cnt0), 64'(m_cnt0));
      chk("cnt1", 64'(pkt_cnt1), 64'(m_cnt1));
      xf0 = 1'b0; xf1 = 1'b0;
      nxt = m_owner;
      if (m_owner < 0) begin
        chk("idle_rdy0", 64'(in0_tready), 0);
        chk("idle_rdy1", 64'(in1_tready), 0);
        chk("idle_ovalid", 64'(out_tvalid), 0);
        gwords = 0;
        if (v[0] && v[1])  nxt = (m_last == 1) ? 0 : 1;
        else if (v[0])     nxt = 0;
        else if (v[1])     nxt = 1;
      end else begin
        n = m_owner;
        chk("ovalid", 64'(out_tvalid), 64'(v[n]));
        chk("rdy_owner", 64'((n == 0) ? in0_tready : in1_tready), 64'(out_tready));
        chk("rdy_other", 64'((n == 0) ? in1_tready : in0_tready), 0);
        if (v[n] && out_tready) begin
          if (n == 0) xf0 = 1'b1; else xf1 = 1'b1;
          gwords++;
          chk("q_nonempty", 64'(qsize(n) != 0), 1);
          if (qsize(n) != 0) begin
            w = (n == 0) ? q0.pop_front() : q1.pop_front();
            chk("data", 64'(out_tdata), 64'(w));
            if (w[33]) begin
              m_last = n;
              if (n == 0) m_cnt0 = (m_cnt0 + 1) % (1 << CW);
              else        m_cnt1 = (m_cnt1 + 1) % (1 << CW);
              nxt = -1;
            end
          end
        end
      end
      if (clear) begin
        nxt = -1; m_cnt0 = 0; m_cnt1 = 0; m_last = 0;
      end
      m_owner = nxt;
    end
  end

  // Packet source: builds a packet, queues its expected words, then offers them with random stalls
  task automatic src(input int i);
    int len;
    bit taken;
    logic [35:0] pw [10];
    forever begin
      if (!gen_en[i]) begin
        v[i] = 1'b0;
        @(posedge sys_clk); #1;
      end else begin
        len = $urandom_range(max_len, min_len);
        for (int k = 0; k < len; k++) begin
          pw[k] = {2'b00, 1'(k == len - 1), 1'(k == 0), 32'($urandom())};
          if (i == 0) q0.push_back(pw[k]); else q1.push_back(pw[k]);
        end
        for (int k = 0; k < len; k++) begin
          d[i] = pw[k];
          taken = 1'b0;
          while (!taken) begin
            v[i] = ($urandom_range(99, 0) >= 32'(stall_pct));
            @(posedge sys_clk);
            taken = (i == 0) ? xf0 : xf1;
            #1;
          end
        end
      end
    end
  endtask

  initial begin
    d[0] = '0; d[1] = '0; v[0] = 1'b0; v[1] = 1'b0;
    gen_en[0] = 1'b0; gen_en[1] = 1'b0;
    fork
      src(0);
      src(1);
    join_none
  end

  initial forever begin
    @(posedge sys_clk); #1;
    out_tready = ($urandom_range(99, 0) < 32'(rdy_pct));
  end

  // Fixed-priority instance: in0 sends an incrementing word sequence in 3-word packets
  int p_seq = 0, p_exp = 0, p_cnt = 0;
  bit p_xf = 1'b0;
  function automatic logic [35:0] pword(input int k);
    return {2'b00, 1'(k % 3 == 2), 1'(k % 3 == 0), 32'(k)};
  endfunction

  initial begin
    p_d0 = pword(0);
    forever begin
      @(posedge sys_clk);
      if (p_xf) p_seq++;
      #1 p_d0 = pword(p_seq);
    end
  end

  always @(negedge sys_clk) begin : prio_monitor
    if (!sys_rst_n) begin
      p_cnt = 0; p_xf = 1'b0;
    end else begin
      chk("p_rdy1", 64'(p_tr1), 0);
      chk("p_cnt1", 64'(p_c1), 0);
      chk("p_cnt0", 64'(p_c0), 64'(p_cnt));
      p_xf = p_tr0;
      if (p_tr0) begin
        chk("p_grant", 64'(p_gr), 1);
        chk("p_data", 64'(p_od), 64'(pword(p_exp)));
        if (p_exp % 3 == 2) p_cnt++;
        p_exp++;
      end
      if (clear) p_cnt = 0;
    end
  end

  task automatic drain();
    int t = 0;
    gen_en[0] = 1'b0; gen_en[1] = 1'b0;
    while ((q0.size() != 0 || q1.size() != 0 || m_owner >= 0) && t < 2000) begin
      @(posedge sys_clk); t++;
    end
    chk("drain_done", 64'(t < 2000), 1);
  endtask

  task automatic run_phase(input bit e0, input bit e1, input int mn, input int mx,
                           input int st, input int rd, input int cp, input int cyc);
    min_len = mn; max_len = mx; stall_pct = st; rdy_pct = rd;
    gen_en[0] = e0; gen_en[1] = e1;
    repeat (cyc) begin
      @(posedge sys_clk); #1;
      clear = ($urandom_range(99, 0) < 32'(cp));
    end
    clear = 1'b0;
    drain();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 0);
    chk({tag, "_cnt0"}, 64'(pkt_cnt0), 0);
    chk({tag, "_cnt1"}, 64'(pkt_cnt1), 0);
    chk({tag, "_ovalid"}, 64'(out_tvalid), 0);
    chk({tag, "_rdy0"}, 64'(in0_tready), 0);
    chk({tag, "_rdy1"}, 64'(in1_tready), 0);
    chk({tag, "_p_grant"}, 64'(p_gr), 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge sys_clk);
    #1 check_all_zero("reset");
    #1 sys_rst_n = 1'b1;

    // Both inputs, continuous 3-word packets: round-robin alternation
    run_phase(1, 1, 3, 3, 0, 100, 0, 80);
    // in0 only, 10-word packets with input and output stalls
    run_phase(1, 0, 10, 10, 40, 60, 0, 150);
    // Mixed random traffic with occasional clears
    run_phase(1, 1, 1, 10, 30, 70, 2, 600);
    // in1 single-word packets: one per two cycles, counter wraps
    run_phase(0, 1, 1, 1, 0, 100, 0, 80);

    // Clear landing on the second word of a 5-word in0 packet
    min_len = 5; max_len = 5; stall_pct = 0; rdy_pct = 100;
    gen_en[0] = 1'b1;
    t = 0;
    while (!(m_owner == 0 && gwords == 1) && t < 200) begin
      @(posedge sys_clk); t++;
    end
    chk("clr_wait", 64'(t < 200), 1);
    #1 clear = 1'b1;
    @(posedge sys_clk); #1 clear = 1'b0;
    chk("clr_grant", 64'(grant), 0);
    chk("clr_cnt0", 64'(pkt_cnt0), 0);
    chk("clr_p_cnt0", 64'(p_c0), 0);
    drain();

    // Asynchronous reset mid-traffic
    min_len = 4; max_len = 8; stall_pct = 20; rdy_pct = 80;
    gen_en[0] = 1'b1; gen_en[1] = 1'b1;
    repeat (37) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    repeat (100) @(posedge sys_clk);
    drain();

    chk("p_progress", 64'(p_exp > 30), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
